// File: rtl/i2c_pkg.sv
// Shared FSM state codes, R/W constants and slot/quarter counter types for the I2C byte master.
package i2c_pkg;

  typedef logic [3:0] i2c_state_t;
  typedef logic [1:0] i2c_quarter_t;
  typedef logic [2:0] i2c_slot_t;

  localparam i2c_state_t ST_IDLE  = 4'd0;
  localparam i2c_state_t ST_START = 4'd1;
  localparam i2c_state_t ST_ADDR  = 4'd2;
  localparam i2c_state_t ST_AACK  = 4'd3;
  localparam i2c_state_t ST_WDATA = 4'd4;
  localparam i2c_state_t ST_WACK  = 4'd5;
  localparam i2c_state_t ST_RDATA = 4'd6;
  localparam i2c_state_t ST_RNACK = 4'd7;
  localparam i2c_state_t ST_STOP  = 4'd8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_byte_master_if.sv
// Sequencer command/status bundle: the sequencer drives the master modport, the byte master sits on slave.
interface i2c_byte_master_if;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_in;
  logic       enable;
  logic [7:0] data_out;
  logic       ready;
  logic       ack_err;

  modport master (output addr, rw, data_in, enable, input data_out, ready, ack_err);
  modport slave  (input addr, rw, data_in, enable, output data_out, ready, ack_err);
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit strobe: one-clock tick every DIV clocks; frozen while hold=1, reset to 0 while clear=1.
module i2c_tick_gen #(
  parameter int DIV = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !clear && !hold && (cnt == LAST);
endmodule

// File: rtl/i2c_byte_master.sv
// One enable -> START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP; ready low 1+80*DIV clks (1+44*DIV on address NACK), enable ignored while busy.
// Optional I2C_CLK_STRETCH_EN: quarter ticks freeze while SCL is released but held low by a slave.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 100_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  i2c_byte_master_if.slave     cmd,
  output logic                 i2c_sda_o,
  input  logic                 i2c_sda_i,
  output logic                 i2c_scl_o,
  input  logic                 i2c_scl_i
);
  localparam int DIV = CLK_HZ / (4 * I2C_HZ);

  i2c_state_t   state;
  i2c_quarter_t q;
  i2c_slot_t    bitn;
  logic [7:0]   tx_sr;
  logic [7:0]   wr_byte;
  logic [7:0]   rx_sr;
  logic [7:0]   data_out_q;
  logic         rw_q;
  logic         ready_q;
  logic         ack_err_q;
  logic         tick;
  logic         hold;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = i2c_scl_o && !i2c_scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = i2c_scl_i;
  assign hold = 1'b0;
`endif

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .hold    (hold),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      q          <= '0;
      bitn       <= '0;
      tx_sr      <= '0;
      wr_byte    <= '0;
      rx_sr      <= '0;
      data_out_q <= 8'h00;
      rw_q       <= I2C_RW_WRITE;
      ready_q    <= 1'b1;
      ack_err_q  <= 1'b0;
    end else if (state == ST_IDLE) begin
      // ready rises one cycle after STOP ends, so an accept is never taken on that cycle
      if (cmd.enable && ready_q) begin
        state     <= ST_START;
        ready_q   <= 1'b0;
        tx_sr     <= {cmd.addr, cmd.rw};
        wr_byte   <= cmd.data_in;
        rw_q      <= cmd.rw;
        ack_err_q <= 1'b0;
        q         <= '0;
        bitn      <= '0;
      end else begin
        ready_q <= 1'b1;
      end
    end else if (tick) begin
      q <= q + 2'd1;
      if (q == 2'd2) begin
        if ((state == ST_AACK || state == ST_WACK) && i2c_sda_i) ack_err_q <= 1'b1;
        if (state == ST_RDATA) rx_sr <= {rx_sr[6:0], i2c_sda_i};
      end
      if (q == 2'd3) begin
        case (state)
          ST_START: state <= ST_ADDR;
          ST_ADDR: begin
            tx_sr <= {tx_sr[6:0], 1'b0};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= ST_AACK;
          end
          ST_AACK: begin
            if (ack_err_q) begin
              state <= ST_STOP;
            end else if (rw_q == I2C_RW_READ) begin
              state <= ST_RDATA;
            end else begin
              state <= ST_WDATA;
              tx_sr <= wr_byte;
            end
          end
          ST_WDATA: begin
            tx_sr <= {tx_sr[6:0], 1'b0};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= ST_WACK;
          end
          ST_RDATA: begin
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= ST_RNACK;
          end
          ST_RNACK: begin
            if (!ack_err_q) data_out_q <= rx_sr;
            state <= ST_STOP;
          end
          ST_WACK: state <= ST_STOP;
          ST_STOP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Line levels are decoded from registered state; data bits change only when a slot starts (q0).
  always_comb begin
    i2c_sda_o = 1'b1;
    i2c_scl_o = 1'b1;
    case (state)
      ST_START: begin
        i2c_sda_o = ~q[1];
        i2c_scl_o = (q != 2'd3);
      end
      ST_ADDR, ST_WDATA: begin
        i2c_sda_o = tx_sr[7];
        i2c_scl_o = q[1];
      end
      ST_AACK, ST_WACK, ST_RDATA, ST_RNACK: begin
        i2c_sda_o = 1'b1;
        i2c_scl_o = q[1];
      end
      ST_STOP: begin
        i2c_sda_o = q[1];
        i2c_scl_o = (q != 2'd0);
      end
      default: begin
        i2c_sda_o = 1'b1;
        i2c_scl_o = 1'b1;
      end
    endcase
  end

  assign cmd.ready    = ready_q;
  assign cmd.ack_err  = ack_err_q;
  assign cmd.data_out = data_out_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: open-drain pad model with a slave at 7'h70, scoreboard on transaction completion.
`timescale 1ns/1ps
module tb_i2c_byte_master;
  localparam int CLK_HZ = 4_000_000;
  localparam int I2C_HZ = 100_000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #125 clk = ~clk;

  i2c_byte_master_if cmd ();
  logic sda_o, scl_o;
  logic slave_sda = 1'b1;
  logic slave_scl = 1'b1;
  wire  sda_bus = sda_o & slave_sda;
  wire  scl_bus = scl_o & slave_scl;

  i2c_byte_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cmd),
    .i2c_sda_o (sda_o),
    .i2c_sda_i (sda_bus),
    .i2c_scl_o (scl_o),
    .i2c_scl_i (scl_bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic       ack_err;
    logic [7:0] dout;
    int         lat;
    int         rises;
    int         nbytes;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_byte_q[$];

  // Slave model: decodes bytes on SCL rise, ACKs address 7'h70 and its write data, serves reads.
  int         bitcnt = 0;
  int         rises = 0;
  int         nbytes = 0;
  logic [7:0] sh = 8'h00;
  logic       addressed = 1'b0;
  logic       rd = 1'b0;
  logic       in_data = 1'b0;
  logic       stop_seen = 1'b0;
  logic [7:0] slave_rd_byte = 8'h00;
  logic       scl_d = 1'b1;
  logic       sda_d = 1'b1;

  always @(posedge clk) begin
    if (scl_bus && scl_d && sda_d && !sda_bus) begin
      bitcnt = 0; rises = 0; nbytes = 0; in_data = 1'b0;
      addressed = 1'b0; rd = 1'b0; stop_seen = 1'b0; slave_sda = 1'b1;
    end else if (scl_bus && scl_d && !sda_d && sda_bus) begin
      stop_seen = 1'b1;
      slave_sda = 1'b1;
    end else if (scl_bus && !scl_d) begin
      rises++;
      if (bitcnt < 8) begin
        sh = {sh[6:0], sda_bus};
        bitcnt++;
      end else if (bitcnt == 8) begin
        if (in_data && rd && addressed) check("rd_master_nack", sda_bus, 1'b1);
        bitcnt = 9;
      end
    end else if (!scl_bus && scl_d) begin
      if (bitcnt == 8) begin
        if (!in_data || !rd) begin
          nbytes++;
          if (exp_byte_q.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_byte_extra actual=%0h required=none", sh);
          end else begin
            check("bus_byte", sh, exp_byte_q.pop_front());
          end
          if (!in_data) begin
            addressed = (sh[7:1] == 7'h70);
            rd = sh[0];
          end
          slave_sda = !addressed;
        end else begin
          slave_sda = 1'b1;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0;
        if (!in_data && addressed) begin
          slave_sda = rd ? slave_rd_byte[7] : 1'b1;
        end else begin
          addressed = 1'b0;
          slave_sda = 1'b1;
        end
        in_data = 1'b1;
      end else if (in_data && rd && addressed && bitcnt >= 1 && bitcnt <= 7) begin
        slave_sda = slave_rd_byte[7 - bitcnt];
      end
    end
    scl_d = scl_bus;
    sda_d = sda_bus;
  end

  // Monitor: on each ready rise, pop the expected transaction and compare.
  int   busy = 0;
  logic prev_rdy = 1'b1;
  exp_t me;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy = 0;
      prev_rdy = 1'b1;
    end else begin
      if (!cmd.ready) begin
        busy++;
      end else if (!prev_rdy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL txn_extra actual=%0d required=none", busy);
        end else begin
          me = exp_q.pop_front();
          check("latency", busy, me.lat);
          check("ack_err", cmd.ack_err, me.ack_err);
          check("data_out", cmd.data_out, me.dout);
          check("scl_rises", rises, me.rises);
          check("bytes_from_master", nbytes, me.nbytes);
          check("stop_seen", stop_seen, 1'b1);
        end
        busy = 0;
      end
      prev_rdy = cmd.ready;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd.ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd.ready) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=busy required=ready", name);
    end
  endtask

  task automatic expect_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                            input logic eack, input logic [7:0] edout,
                            input int lat, input int nr, input int nb);
    exp_t e;
    e.ack_err = eack; e.dout = edout; e.lat = lat; e.rises = nr; e.nbytes = nb;
    exp_q.push_back(e);
    exp_byte_q.push_back({a, r});
    if (!r && !eack) exp_byte_q.push_back(d);
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d,
                       input logic [7:0] rdb, input logic eack, input logic [7:0] edout,
                       input int lat, input int nr, input int nb);
    wait_ready("pre_issue");
    expect_txn(a, r, d, eack, edout, lat, nr, nb);
    slave_rd_byte = rdb;
    @(negedge clk);
    cmd.addr = a; cmd.rw = r; cmd.data_in = d; cmd.enable = 1'b1;
    @(posedge clk);
    #1 cmd.enable = 1'b0;
    @(negedge clk);
    wait_ready("txn");
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic stretch();
    int   r = 0;
    int   n = 0;
    logic p = 1'b1;
    logic s0;
    logic chg = 1'b0;
    while (r < 3 && n < 3000) begin
      @(posedge clk);
      #1;
      if (scl_o && !p) r++;
      p = scl_o;
      n++;
    end
    check("stretch_found_bit", r, 3);
    slave_scl = 1'b0;
    s0 = sda_o;
    repeat (37) begin
      @(posedge clk);
      #1;
      if (sda_o !== s0) chg = 1'b1;
    end
    slave_scl = 1'b1;
    check("stretch_sda_stable", chg, 1'b0);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd.enable = 1'b0; cmd.addr = 7'h00; cmd.rw = 1'b0; cmd.data_in = 8'h00;
    #10 reset_n = 1'b0;
    #300;
    check("rst_ready", cmd.ready, 1'b1);
    check("rst_ack_err", cmd.ack_err, 1'b0);
    check("rst_data_out", cmd.data_out, 8'h00);
    check("rst_sda", sda_o, 1'b1);
    check("rst_scl", scl_o, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(7'h70, 1'b0, 8'h51, 8'h00, 1'b0, 8'h00, 801, 19, 2);
    issue(7'h70, 1'b1, 8'h00, 8'h1A, 1'b0, 8'h1A, 801, 19, 1);
    issue(7'h70, 1'b1, 8'h00, 8'hF3, 1'b0, 8'hF3, 801, 19, 1);
    issue(7'h22, 1'b0, 8'h99, 8'h00, 1'b1, 8'hF3, 441, 10, 1);

    // enable held high: three back-to-back transactions, each re-accepted on its single ready cycle
    for (int k = 0; k < 3; k++) expect_txn(7'h70, 1'b0, 8'h3C, 1'b0, 8'hF3, 801, 19, 2);
    @(negedge clk);
    cmd.addr = 7'h70; cmd.rw = 1'b0; cmd.data_in = 8'h3C; cmd.enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_ready("hold");
      if (k < 2) begin
        @(negedge clk);
        check("hold_ready_one_cycle", cmd.ready, 1'b0);
        if (k == 1) cmd.enable = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    check("hold_no_extra_ready", cmd.ready, 1'b1);
    check("hold_no_extra_txn", exp_q.size(), 0);

    // reset in the middle of address slot 5 (SCL and SDA both low there)
    @(negedge clk);
    cmd.addr = 7'h70; cmd.rw = 1'b0; cmd.data_in = 8'h77; cmd.enable = 1'b1;
    @(posedge clk);
    #1 cmd.enable = 1'b0;
    repeat (205) @(posedge clk);
    #1;
    check("pre_rst_scl_low", scl_o, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_sda", sda_o, 1'b1);
    check("midrst_scl", scl_o, 1'b1);
    check("midrst_ready", cmd.ready, 1'b1);
    check("midrst_data_out", cmd.data_out, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(7'h70, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 801, 19, 2);

`ifdef I2C_CLK_STRETCH_EN
    fork
      issue(7'h70, 1'b0, 8'hC3, 8'h00, 1'b0, 8'h00, 838, 19, 2);
      stretch();
    join
`endif

    repeat (10) @(negedge clk);
    check("txn_queue_drained", exp_q.size(), 0);
    check("byte_queue_drained", exp_byte_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
